// File: rtl/maple_rx_payload.sv
// maple_rx_payload
//   Payload path of the Maple bus receiver. It turns synchronized SDCKA/SDCKB
//   edge strobes into bytes and holds one byte back, so the final byte of a
//   frame can be tagged with TLAST when the frame-control FSM closes the
//   store window. It also watches the lines for the Maple end-of-frame
//   pattern.
//
// Ports
//   aclk, aresetn          : clock, asynchronous active-low reset
//   enable                 : frame-store window from the FSM; 1->0 ends frame
//   sdcka_data/sdckb_data  : synchronized line levels
//   sdck{a,b}_{pos,neg}edge: single-cycle edge strobes aligned with levels
//   m_tdata/m_tvalid/...   : AXI-Stream master, no backpressure
//   end_frame              : one-cycle pulse, valid end pattern seen
//   end_frame_error        : one-cycle pulse, malformed end pattern seen
module maple_rx_payload #(
    // Only 8 is meaningful: the decoder assembles exactly one byte per beat.
    parameter int C_M_AXIS_TDATA_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            enable,
    input  logic                            sdcka_data,
    input  logic                            sdckb_data,
    input  logic                            sdcka_posedge,
    input  logic                            sdcka_negedge,
    input  logic                            sdckb_posedge,
    input  logic                            sdckb_negedge,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_tdata,
    output logic                            m_tvalid,
    output logic                            m_tstrb,
    output logic                            m_tkeep,
    output logic                            m_tlast,
    output logic                            end_frame,
    output logic                            end_frame_error
);

    localparam int DW = C_M_AXIS_TDATA_WIDTH;

    // End-frame detector states
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_B_LOW = 1'b1;

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [2:0]    r_bit_idx;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] r_byte;
    logic          r_byte_vld;

    logic          w_expect_a;
    logic          w_take;
    logic          w_bit;
    logic [DW-1:0] w_next_shift;

    // Odd bit indices are carried on the A-fall phase (data on B), even
    // indices on the B-fall phase (data on A).
    assign w_expect_a   = r_bit_idx[0];
    assign w_take       = ~(sdcka_negedge & sdckb_negedge) &
                          (w_expect_a ? sdcka_negedge : sdckb_negedge);
    assign w_bit        = w_expect_a ? sdckb_data : sdcka_data;
    assign w_next_shift = {r_shift[DW-2:0], w_bit};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bit_idx  <= 3'd7;
            r_shift    <= '0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            if (!enable) begin
                // Outside the store window any partial byte is thrown away.
                r_bit_idx <= 3'd7;
                r_shift   <= '0;
            end else if (w_take) begin
                r_shift <= w_next_shift;
                if (r_bit_idx == 3'd0) begin
                    r_byte     <= w_next_shift;
                    r_byte_vld <= 1'b1;
                    r_bit_idx  <= 3'd7;
                end else begin
                    r_bit_idx <= r_bit_idx - 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One-byte holdback buffer
    // ------------------------------------------------------------------
    logic          r_enable_d;
    logic          r_pend;
    logic [DW-1:0] r_pend_byte;
    logic [DW-1:0] r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          w_en_fall;

    assign w_en_fall = r_enable_d & ~enable;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_enable_d  <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_byte <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
        end else begin
            r_enable_d <= enable;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            if (w_en_fall) begin
                // Frame closed: the held byte is the last one. A byte
                // completing at this moment belongs to no frame and is lost.
                if (r_pend) begin
                    r_tdata  <= r_pend_byte;
                    r_tvalid <= 1'b1;
                    r_tlast  <= 1'b1;
                end
                r_pend <= 1'b0;
            end else if (r_byte_vld && enable) begin
                if (r_pend) begin
                    r_tdata  <= r_pend_byte;
                    r_tvalid <= 1'b1;
                end
                r_pend      <= 1'b1;
                r_pend_byte <= r_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // End-frame detector: B held low while A pulses; two A pulses is the
    // end pattern, any other non-zero count is a framing error, and zero
    // is just an ordinary B-phase data bit.
    // ------------------------------------------------------------------
    logic [0:0] r_ef_state;
    logic [1:0] r_a_cnt;
    logic       r_end_frame;
    logic       r_end_frame_error;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ef_state        <= S_IDLE;
            r_a_cnt           <= 2'd0;
            r_end_frame       <= 1'b0;
            r_end_frame_error <= 1'b0;
        end else begin
            r_end_frame       <= 1'b0;
            r_end_frame_error <= 1'b0;
            case (r_ef_state)
                S_IDLE: begin
                    // An A fall coinciding with the entering B fall is
                    // deliberately not counted.
                    if (sdckb_negedge) begin
                        r_ef_state <= S_B_LOW;
                        r_a_cnt    <= 2'd0;
                    end
                end
                S_B_LOW: begin
                    if (sdckb_posedge) begin
                        r_end_frame       <= (r_a_cnt == 2'd2);
                        r_end_frame_error <= (r_a_cnt == 2'd1) || (r_a_cnt == 2'd3);
                        r_ef_state        <= S_IDLE;
                    end else if (sdcka_negedge && (r_a_cnt != 2'd3)) begin
                        r_a_cnt <= r_a_cnt + 2'd1;
                    end
                end
                default: r_ef_state <= S_IDLE;
            endcase
        end
    end

    // A rising edges carry no information for this path.
    logic w_unused;
    assign w_unused = sdcka_posedge;

    assign m_tdata         = r_tdata;
    assign m_tvalid        = r_tvalid;
    assign m_tlast         = r_tlast;
    assign m_tstrb         = 1'b1;
    assign m_tkeep         = 1'b1;
    assign end_frame       = r_end_frame;
    assign end_frame_error = r_end_frame_error;

endmodule

// File: tb/tb_maple_rx_payload.sv
module tb_maple_rx_payload;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       enable;
    logic       sdcka_data, sdckb_data;
    logic       sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tstrb, m_tkeep, m_tlast;
    logic       end_frame, end_frame_error;

    always #5 aclk = ~aclk;

    maple_rx_payload #(.C_M_AXIS_TDATA_WIDTH(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .sdcka_data(sdcka_data), .sdckb_data(sdckb_data),
        .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
        .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tstrb(m_tstrb),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .end_frame(end_frame), .end_frame_error(end_frame_error)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] ef_q[$];   // {error, end_frame}
    int         n_cmp = 0;
    int         n_err = 0;
    logic       tb_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge aclk) begin
        if (aresetn && !tb_done) begin
            if (m_tvalid) begin
                if (exp_q.size() == 0) chk("beat_unexp", {31'd0, m_tvalid}, 32'd0);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", {24'd0, m_tdata}, {24'd0, e.data});
                    chk("beat_last", {31'd0, m_tlast}, {31'd0, e.last});
                end
            end else begin
                chk("tlast_idle", {31'd0, m_tlast}, 32'd0);
            end
            if (end_frame || end_frame_error) begin
                if (ef_q.size() == 0)
                    chk("ef_unexp", {30'd0, end_frame_error, end_frame}, 32'd0);
                else begin
                    logic [1:0] k;
                    k = ef_q.pop_front();
                    chk("ef_kind", {30'd0, end_frame_error, end_frame}, {30'd0, k});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic a_fall(input logic bdat);
        @(negedge aclk);
        sdckb_data = bdat; sdcka_data = 1'b0; sdcka_negedge = 1'b1;
        @(negedge aclk);
        sdcka_negedge = 1'b0;
    endtask

    task automatic a_rise();
        @(negedge aclk);
        sdcka_data = 1'b1; sdcka_posedge = 1'b1;
        @(negedge aclk);
        sdcka_posedge = 1'b0;
    endtask

    task automatic b_fall(input logic adat);
        @(negedge aclk);
        sdcka_data = adat; sdckb_data = 1'b0; sdckb_negedge = 1'b1;
        @(negedge aclk);
        sdckb_negedge = 1'b0;
    endtask

    task automatic b_rise();
        @(negedge aclk);
        sdckb_data = 1'b1; sdckb_posedge = 1'b1;
        @(negedge aclk);
        sdckb_posedge = 1'b0;
    endtask

    // Send the top n bits of b, MSB first, with realistic alternating phases.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            if (i % 2 == 1) begin a_fall(b[i]); a_rise(); end
            else            begin b_fall(b[i]); b_rise(); end
        end
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l);
        beat_t e;
        e.data = d; e.last = l;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; enable = 1'b0;
        sdcka_data = 1'b1; sdckb_data = 1'b1;
        sdcka_posedge = 1'b0; sdcka_negedge = 1'b0;
        sdckb_posedge = 1'b0; sdckb_negedge = 1'b0;
        idle(3);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata",  {24'd0, m_tdata},  32'd0);
        chk("rst_tlast",  {31'd0, m_tlast},  32'd0);
        chk("rst_tstrb",  {31'd0, m_tstrb},  32'd1);
        chk("rst_tkeep",  {31'd0, m_tkeep},  32'd1);
        chk("rst_ef",     {30'd0, end_frame_error, end_frame}, 32'd0);
        aresetn = 1'b1;
        idle(3);

        // Three-byte frame
        push_beat(8'hA5, 1'b0); push_beat(8'h3C, 1'b0); push_beat(8'hFF, 1'b1);
        enable = 1'b1; idle(2);
        send_bits(8'hA5, 8); send_bits(8'h3C, 8); send_bits(8'hFF, 8);
        idle(3); enable = 1'b0; idle(5);
        chk("frame_drained", exp_q.size(), 32'd0);

        // End pattern inside the store window; stray bit-7 sample discarded
        ef_q.push_back(2'b01);
        enable = 1'b1; idle(2);
        b_fall(1'b1); a_fall(1'b0); a_rise(); a_fall(1'b0); a_rise(); b_rise();
        idle(3); enable = 1'b0; idle(4);

        // Error patterns and the zero-count case, outside the window
        ef_q.push_back(2'b10);
        b_fall(1'b1); a_fall(1'b0); a_rise(); b_rise(); idle(3);
        ef_q.push_back(2'b10);
        b_fall(1'b1);
        repeat (3) begin a_fall(1'b0); a_rise(); end
        b_rise(); idle(3);
        b_fall(1'b1); b_rise(); idle(3);

        // A fall coincident with entering B fall is not counted: 2 more -> end_frame
        ef_q.push_back(2'b01);
        @(negedge aclk);
        sdckb_negedge = 1'b1; sdcka_negedge = 1'b1; sdcka_data = 1'b0; sdckb_data = 1'b0;
        @(negedge aclk);
        sdckb_negedge = 1'b0; sdcka_negedge = 1'b0;
        a_rise(); a_fall(1'b0); a_rise(); a_fall(1'b0); a_rise(); b_rise(); idle(3);
        chk("ef_drained", ef_q.size(), 32'd0);

        // Bytes on the lines while disabled, then an empty frame
        send_bits(8'h5A, 8); send_bits(8'hC3, 8); idle(4);
        enable = 1'b1; idle(4); enable = 1'b0; idle(4);

        // Full byte followed by a 5-bit partial
        push_beat(8'h81, 1'b1);
        enable = 1'b1; idle(2);
        send_bits(8'h81, 8); send_bits(8'hC8, 5);
        idle(2); enable = 1'b0; idle(4);

        // Wrong-line strobe and simultaneous negedges are both ignored
        push_beat(8'hB4, 1'b1);
        enable = 1'b1; idle(2);
        a_fall(1'b1); a_rise();            // bit7 = 1
        a_fall(1'b0); a_rise();            // A while B expected: ignored
        @(negedge aclk);
        sdcka_negedge = 1'b1; sdckb_negedge = 1'b1; sdcka_data = 1'b1; sdckb_data = 1'b1;
        @(negedge aclk);
        sdcka_negedge = 1'b0; sdckb_negedge = 1'b0;
        b_rise();
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'hB4;
            if (i % 2 == 1) begin a_fall(v[i]); a_rise(); end
            else            begin b_fall(v[i]); b_rise(); end
        end
        idle(2); enable = 1'b0; idle(4);

        // Byte whose final strobe lands in the first disabled cycle is dropped
        push_beat(8'h11, 1'b1);
        enable = 1'b1; idle(2);
        send_bits(8'h11, 8); send_bits(8'h22, 7);
        @(negedge aclk);
        sdcka_data = 1'b0; sdckb_data = 1'b0; sdckb_negedge = 1'b1; enable = 1'b0;
        @(negedge aclk);
        sdckb_negedge = 1'b0;
        b_rise(); idle(4);

        // Reset mid-frame with a pending byte
        enable = 1'b1; idle(2);
        send_bits(8'h55, 8); send_bits(8'hF0, 3);
        @(negedge aclk); aresetn = 1'b0;
        @(negedge aclk);
        chk("mrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mrst_tdata",  {24'd0, m_tdata},  32'd0);
        chk("mrst_tlast",  {31'd0, m_tlast},  32'd0);
        chk("mrst_tstrb",  {31'd0, m_tstrb},  32'd1);
        chk("mrst_ef",     {30'd0, end_frame_error, end_frame}, 32'd0);
        aresetn = 1'b1;
        idle(3); enable = 1'b0; idle(6);

        chk("beats_left", exp_q.size(), 32'd0);
        chk("ef_left", ef_q.size(), 32'd0);
        tb_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
